// File: rtl/inst_queue.sv
// -----------------------------------------------------------------------------
// inst_queue
//   Instruction queue between the IF and ID stages. Fetch can run ahead while ID
//   stalls, and the queue hands packets to ID in program order. An exception,
//   an ertn or a taken branch raises flush, which empties the queue. Toward IF
//   the queue presents the same valid/allowin handshake that ID would.
//
//   Packet layout: {adef, wrong_addr[31:0], pc[31:0], inst[31:0], tlb_zombie}.
//   The payload is never inspected.
//
//   Optional feature macro: IQ_BYPASS_EN
//     When it is defined, an empty queue forwards the offered packet to ID in
//     the same cycle. The packet is written into the queue only if ID stalls.
//     When it is undefined, the minimum latency is one cycle and no
//     combinational path runs from input to output.
//
// Ports
//   clk          clock; all state updates on posedge
//   reset        synchronous, active-high reset
//   if_iq_valid  IF offers a packet this cycle
//   if_iq_bus    packet from IF
//   iq_allowin   queue accepts a packet this cycle (to IF)
//   iq_id_valid  head packet valid toward ID
//   iq_id_bus    head packet
//   id_allowin   ID consumes the head this cycle
//   flush        discards all contents, highest priority
//   iq_count     current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module inst_queue #(
   parameter int DEPTH = 4,   // power of two, >= 2
   parameter int BUS_W = 98
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     if_iq_valid,
   input  logic [BUS_W-1:0]         if_iq_bus,
   output logic                     iq_allowin,
   output logic                     iq_id_valid,
   output logic [BUS_W-1:0]         iq_id_bus,
   input  logic                     id_allowin,
   input  logic                     flush,
   output logic [$clog2(DEPTH):0]   iq_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [BUS_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rptr;
   logic [PTR_W-1:0] wptr;
   logic [CNT_W-1:0] count;

   logic empty;
   logic full;
   logic push;
   logic pop;

   assign empty = (count == '0);
   assign full  = (count == FULL_CNT);

   // allowin looks only at registered occupancy. A full queue refuses a packet
   // even when ID drains the head in the same cycle, which keeps id_allowin
   // out of the IF timing path.
   assign iq_allowin = ~reset & ~flush & ~full;

`ifdef IQ_BYPASS_EN
   logic bypass_hit;

   // An empty queue shows the incoming packet straight to ID.
   assign bypass_hit  = empty & if_iq_valid & ~flush & ~reset;
   assign iq_id_valid = (~empty | bypass_hit) & ~flush & ~reset;
   assign iq_id_bus   = empty ? if_iq_bus : mem[rptr];
   // A bypassed packet that ID takes at once is never stored.
   assign push        = if_iq_valid & iq_allowin & ~(bypass_hit & id_allowin);
`else
   assign iq_id_valid = ~empty & ~flush & ~reset;
   assign iq_id_bus   = mem[rptr];
   assign push        = if_iq_valid & iq_allowin;
`endif

   // A pop is a dequeue from storage. A bypassed packet (empty queue) does not
   // count as one.
   assign pop = iq_id_valid & id_allowin & ~empty;

   assign iq_count = count;

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         rptr  <= '0;
         wptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + PTR_W'(1);
         if (pop)  rptr <= rptr + PTR_W'(1);
         unique case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // NOTE: the payload array has no reset. Occupancy alone decides validity,
   // so resetting the array would only add reset fan-out.
   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= if_iq_bus;
   end

endmodule

// File: tb/tb_inst_queue.sv
// -----------------------------------------------------------------------------
// tb_inst_queue
//   Self-checking bench for inst_queue. A scoreboard queue holds the packets
//   the queue should contain. Every cycle the bench compares occupancy, the
//   handshake outputs and the head packet with that model. The build follows
//   IQ_BYPASS_EN the same way the RTL does.
// -----------------------------------------------------------------------------
module tb_inst_queue;

   localparam int DEPTH = 4;
   localparam int BUS_W = 98;

   logic                   clk = 1'b0;
   logic                   reset;
   logic                   if_iq_valid;
   logic [BUS_W-1:0]       if_iq_bus;
   logic                   iq_allowin;
   logic                   iq_id_valid;
   logic [BUS_W-1:0]       iq_id_bus;
   logic                   id_allowin;
   logic                   flush;
   logic [$clog2(DEPTH):0] iq_count;

   int n_compared   = 0;
   int n_mismatched = 0;

   logic [BUS_W-1:0] sb [$];

   inst_queue #(.DEPTH(DEPTH), .BUS_W(BUS_W)) dut (
      .clk         (clk),
      .reset       (reset),
      .if_iq_valid (if_iq_valid),
      .if_iq_bus   (if_iq_bus),
      .iq_allowin  (iq_allowin),
      .iq_id_valid (iq_id_valid),
      .iq_id_bus   (iq_id_bus),
      .id_allowin  (id_allowin),
      .flush       (flush),
      .iq_count    (iq_count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [BUS_W-1:0] got,
                        input logic [BUS_W-1:0] exp);
      n_compared++;
      if (got !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Packet: {adef, wrong_addr, pc, inst, tlb_zombie}. adef and tlb_zombie are
   // taken from pc bits so that the flag bits also vary.
   function automatic logic [BUS_W-1:0] pkt(input logic [31:0] pc,
                                            input logic [31:0] inst);
      return {pc[2], ~pc, pc, inst, pc[3]};
   endfunction

   // One clock cycle: drive the inputs, check the outputs against the model,
   // then advance the model the way the queue should advance.
   task automatic step(input logic v, input logic [BUS_W-1:0] b,
                       input logic ida, input logic fl);
      logic exp_allow;
      logic exp_valid;
      bit   byp;
      @(negedge clk);
      if_iq_valid = v;
      if_iq_bus   = b;
      id_allowin  = ida;
      flush       = fl;
      #1;
      exp_allow = !fl && (sb.size() != DEPTH);
      exp_valid = !fl && (sb.size() != 0);
      byp       = 1'b0;
`ifdef IQ_BYPASS_EN
      if (!fl && sb.size() == 0 && v) begin
         byp       = 1'b1;
         exp_valid = 1'b1;
      end
`endif
      check("count",   BUS_W'(iq_count),    BUS_W'(sb.size()));
      check("allowin", BUS_W'(iq_allowin),  BUS_W'(exp_allow));
      check("valid",   BUS_W'(iq_id_valid), BUS_W'(exp_valid));
      if (exp_valid) check("head", iq_id_bus, byp ? b : sb[0]);
      if (fl) begin
         sb.delete();
      end else begin
         if (exp_valid && ida && !byp) void'(sb.pop_front());
         if (v && exp_allow && !(byp && ida)) sb.push_back(b);
      end
   endtask

   task automatic idle();
      step(1'b0, '0, 1'b0, 1'b0);
   endtask

   // Hold reset for the given number of cycles. A packet is offered the whole
   // time and must be refused.
   task automatic do_reset(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         reset       = 1'b1;
         if_iq_valid = 1'b1;
         if_iq_bus   = pkt(32'hdead_0000, 32'h0);
         id_allowin  = 1'b1;
         flush       = 1'b0;
         #1;
         check("rst_valid",   BUS_W'(iq_id_valid), '0);
         check("rst_allowin", BUS_W'(iq_allowin),  '0);
      end
      @(negedge clk);
      reset       = 1'b0;
      if_iq_valid = 1'b0;
      id_allowin  = 1'b0;
      sb.delete();
   endtask

   initial begin
      reset       = 1'b1;
      if_iq_valid = 1'b0;
      if_iq_bus   = '0;
      id_allowin  = 1'b0;
      flush       = 1'b0;

      // Reset state.
      do_reset(2);
      idle();

      // Fill to full while ID stalls. The idle step then checks count=4,
      // allowin=0 and head pc 0x1c000000.
      for (int i = 0; i < 4; i++)
         step(1'b1, pkt(32'h1c00_0000 + 32'(4*i), 32'h0280_0000 + 32'(i)), 1'b0, 1'b0);
      idle();
      // A full queue refuses input.
      step(1'b1, pkt(32'h1c00_0fff, 32'h1111_1111), 1'b0, 1'b0);

      // Drain in order: count 4,3,2,1, then an empty queue.
      for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);
      idle();

      // Stream 10 packets with ID always ready. The pointers wrap past entry 3.
      for (int i = 0; i < 10; i++)
         step(1'b1, pkt(32'h1c00_0100 + 32'(4*i), 32'h0a00_0000 + 32'(i)), 1'b1, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);
      idle();

      // Three queued, then flush with a packet offered. That packet is dropped.
      for (int i = 0; i < 3; i++)
         step(1'b1, pkt(32'h1c00_0200 + 32'(4*i), 32'h0b00_0000 + 32'(i)), 1'b0, 1'b0);
      step(1'b1, pkt(32'h1c00_0bad, 32'h0bad_0bad), 1'b0, 1'b1);
      idle();
      step(1'b1, pkt(32'h1c00_0300, 32'h0c00_0000), 1'b1, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);
      idle();

      // Full queue with a pop in the same cycle still refuses the offered packet.
      for (int i = 0; i < 4; i++)
         step(1'b1, pkt(32'h1c00_0400 + 32'(4*i), 32'h0d00_0000 + 32'(i)), 1'b0, 1'b0);
      step(1'b1, pkt(32'h1c00_0eee, 32'h0eee_0eee), 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
      idle();

      // Two queued, then a one-cycle reset. The next push must reach the head.
      for (int i = 0; i < 2; i++)
         step(1'b1, pkt(32'h1c00_0500 + 32'(4*i), 32'h0f00_0000 + 32'(i)), 1'b0, 1'b0);
      do_reset(1);
      idle();
      step(1'b1, pkt(32'h1c00_0600, 32'h1200_0000), 1'b0, 1'b0);
      idle();
      step(1'b0, '0, 1'b1, 1'b0);
      idle();

      // Empty queue, inst 0x02800400, ID ready. With bypass the packet leaves in
      // the same cycle and count stays 0. Without bypass it leaves next cycle.
      step(1'b1, pkt(32'h1c00_0700, 32'h0280_0400), 1'b1, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);
      idle();
      // Empty queue, ID stalled. The packet must be stored and then presented.
      step(1'b1, pkt(32'h1c00_0704, 32'h0280_0800), 1'b0, 1'b0);
      idle();
      step(1'b0, '0, 1'b1, 1'b0);
      idle();

      check("sb_empty", BUS_W'(sb.size()), '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
